fetch_stage: RTL and testbench

Instruction-fetch front end for the pipelined MIPS core. It owns the PC register, drives the combinational instruction memory, and holds fetched instructions in a 2-entry buffer with a valid/ready handshake to the decode stage. It accepts a single redirect (taken branch or jump) from downstream, which flushes all wrong-path instructions.

---
 rtl/pipeline_pkg.sv | 14 +
 rtl/fetch_buffer.sv | 49 ++++
 rtl/fetch_stage.sv | 67 ++++++
 tb/tb_fetch_stage.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants used by the fetch stage and later stage registers.
package pipeline_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc4;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetch entries with flush; head entry is presented combinationally.
module fetch_buffer
    import pipeline_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         enq,
    input  logic         deq,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t mem [2];
    logic         head_ptr;
    logic         tail_ptr;

    // Flush keeps entry contents so the head outputs stay stable while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
            mem[0]   <= '0;
            mem[1]   <= '0;
        end else if (flush) begin
            count    <= '0;
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
        end else begin
            if (enq) begin
                mem[tail_ptr] <= wdata;
                tail_ptr      <= ~tail_ptr;
            end
            if (deq) begin
                head_ptr <= ~head_ptr;
            end
            case ({enq, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[head_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, imem addressing, redirect handling and
// a two-entry buffer feeding decode through a valid/ready handshake.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        startin,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
);

    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic [31:0]  redirect_target;
    logic [1:0]   count;
    logic         enq;
    logic         deq;
    fetch_entry_t wentry;
    fetch_entry_t head;

    assign pc_plus4        = pc + 32'd4;
    assign redirect_target = redirect_pc & ~32'd3;

    assign deq = id_valid && id_ready;
    // A full buffer still accepts a fetch when its head leaves in the same cycle.
    assign enq = !redirect_valid && ((count < 2'(DEPTH)) || deq);

    assign wentry = '{pc: pc, pc4: pc_plus4, instr: imem_instr};

    always_ff @(posedge clk) begin
        if (startin) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_target;
        end else if (enq) begin
            pc <= pc_plus4;
        end
    end

    fetch_buffer u_buffer (
        .clk   (clk),
        .rst   (startin),
        .enq   (enq),
        .deq   (deq),
        .flush (redirect_valid),
        .wdata (wentry),
        .count (count),
        .head  (head)
    );

    assign imem_addr = pc;
    assign id_valid  = (count != 2'd0);
    assign id_instr  = head.instr;
    assign id_pc     = head.pc;
    assign id_pc4    = head.pc4;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: two instances (default and wrapping reset PC) driven in lockstep
// and compared every cycle against a queue-based reference model.
module tb_fetch_stage;
    import pipeline_pkg::*;

    localparam logic [31:0] RPC0 = 32'h0000_0000;
    localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        startin = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b0;

    logic [31:0] imem_addr0, imem_instr0, id_instr0, id_pc0, id_pc40;
    logic [31:0] imem_addr1, imem_instr1, id_instr1, id_pc1, id_pc41;
    logic        id_valid0, id_valid1;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0]  mpc0, mpc1;
    fetch_entry_t mq0[$];
    fetch_entry_t mq1[$];

    always #5 clk = ~clk;

    assign imem_instr0 = imem_addr0 ^ 32'hA5A5_0000;
    assign imem_instr1 = imem_addr1 ^ 32'hA5A5_0000;

    fetch_stage #(.RESET_PC(RPC0), .DEPTH(2)) dut0 (
        .clk(clk), .startin(startin), .imem_addr(imem_addr0), .imem_instr(imem_instr0),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid0), .id_ready(id_ready), .id_instr(id_instr0),
        .id_pc(id_pc0), .id_pc4(id_pc40)
    );

    fetch_stage #(.RESET_PC(RPC1), .DEPTH(2)) dut1 (
        .clk(clk), .startin(startin), .imem_addr(imem_addr1), .imem_instr(imem_instr1),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid1), .id_ready(id_ready), .id_instr(id_instr1),
        .id_pc(id_pc1), .id_pc4(id_pc41)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle of the reference behaviour, evaluated with the inputs present before the edge.
    task automatic model_step(input logic [31:0] rst_pc, inout logic [31:0] mpc,
                              inout fetch_entry_t mq[$]);
        logic dq, eq;
        if (startin) begin
            mpc = rst_pc;
            mq.delete();
        end else if (redirect_valid) begin
            mpc = {redirect_pc[31:2], 2'b00};
            mq.delete();
        end else begin
            dq = (mq.size() != 0) && id_ready;
            eq = (mq.size() < 2) || dq;
            if (dq) void'(mq.pop_front());
            if (eq) begin
                mq.push_back('{pc: mpc, pc4: mpc + 32'd4, instr: mpc ^ 32'hA5A5_0000});
                mpc = mpc + 32'd4;
            end
        end
    endtask

    task automatic cycle(input logic rst, input logic rdy, input logic rv,
                         input logic [31:0] rpc, input bit do_check);
        startin        = rst;
        id_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(negedge clk);
        if (do_check) begin
            check("addr0", imem_addr0, mpc0);
            check("valid0", 32'(id_valid0), 32'(mq0.size() != 0));
            if (mq0.size() != 0) begin
                check("pc0", id_pc0, mq0[0].pc);
                check("pc4_0", id_pc40, mq0[0].pc4);
                check("instr0", id_instr0, mq0[0].instr);
            end
            check("addr1", imem_addr1, mpc1);
            check("valid1", 32'(id_valid1), 32'(mq1.size() != 0));
            if (mq1.size() != 0) begin
                check("pc1", id_pc1, mq1[0].pc);
                check("pc4_1", id_pc41, mq1[0].pc4);
                check("instr1", id_instr1, mq1[0].instr);
            end
        end
        model_step(RPC0, mpc0, mq0);
        model_step(RPC1, mpc1, mq1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);

        // Reset state: entries read as zero.
        check("rst_addr0", imem_addr0, RPC0);
        check("rst_addr1", imem_addr1, RPC1);
        check("rst_valid0", 32'(id_valid0), 32'd0);
        check("rst_instr0", id_instr0, 32'd0);
        check("rst_pc0", id_pc0, 32'd0);
        check("rst_pc4_0", id_pc40, 32'd0);

        // Free-running consumer; dut1 exercises the PC wrap.
        repeat (5) cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);

        // Stall from reset: buffer fills, pc holds at 8, head stays at 0.
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        repeat (5) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        check("stall_addr", imem_addr0, 32'h8);
        check("stall_head", id_pc0, 32'h0);
        repeat (4) cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);

        // Redirect while full.
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b1);
        check("redir_valid", 32'(id_valid0), 32'd0);
        check("redir_addr", imem_addr0, 32'h0000_0100);
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);
        check("redir_head", id_pc0, 32'h0000_0100);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);

        // Redirect coinciding with a handshake.
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_2000, 1'b1);
        repeat (4) cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);

        // Reset wins over redirect with a full buffer.
        repeat (3) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_4000, 1'b1);
        check("rst_mid_addr", imem_addr0, RPC0);
        check("rst_mid_valid", 32'(id_valid0), 32'd0);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(63) == 0),
                  ($urandom_range(9) < 7),
                  ($urandom_range(7) == 0),
                  $urandom(), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
